fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 50 +++++
 tb/tb_fetch_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control inputs from decode/execute, instruction-memory
// address/data, and the IF/ID pipeline register outputs.
interface fetch_stage_if;
  localparam int unsigned XLEN = 32;

  logic            Stall;
  logic            Flush;
  logic            Redirect;
  logic [XLEN-1:0] RedirectTarget;
  logic [XLEN-1:0] Instruction;
  logic [XLEN-1:0] PCAddress;
  logic [XLEN-1:0] IFID_Instruction;
  logic [XLEN-1:0] IFID_PCPlus4;
  logic            IFID_Valid;

  // Fetch stage side: owns PC and the IF/ID register.
  modport master (
    input  Stall, Flush, Redirect, RedirectTarget, Instruction,
    output PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid
  );

  // Pipeline/memory side: drives control and the fetched word.
  modport slave (
    output Stall, Flush, Redirect, RedirectTarget, Instruction,
    input  PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with redirect/stall sequencing and
// the IF/ID pipeline register with squash support.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic           Clk,
  input logic           Rst,
  fetch_stage_if.master bus
);
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] ifid_instr;
  logic [XLEN-1:0] ifid_pcplus4;
  logic            ifid_valid;

  // Sequential successor, wraps modulo 2^32.
  assign pc_plus4 = pc + XLEN'(4);

  // PC register: reset > redirect > stall > sequential.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc <= RESET_PC;
    end else if (bus.Redirect) begin
      pc <= {bus.RedirectTarget[XLEN-1:2], 2'b00};
    end else if (!bus.Stall) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID register: reset > squash (flush or redirect) > stall > capture.
  always_ff @(posedge Clk) begin
    if (Rst || bus.Flush || bus.Redirect) begin
      ifid_instr   <= NOP_WORD;
      ifid_pcplus4 <= '0;
      ifid_valid   <= 1'b0;
    end else if (!bus.Stall) begin
      ifid_instr   <= bus.Instruction;
      ifid_pcplus4 <= pc_plus4;
      ifid_valid   <= 1'b1;
    end
  end

  assign bus.PCAddress        = pc;
  assign bus.IFID_Instruction = ifid_instr;
  assign bus.IFID_PCPlus4     = ifid_pcplus4;
  assign bus.IFID_Valid       = ifid_valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run against a behavioural model of the PC / IF/ID rules.
module tb_fetch_stage;
  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TB_NOP      = 32'h0000_0020;

  logic Clk = 1'b0;
  logic Rst;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(TB_RESET_PC), .NOP_WORD(TB_NOP)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus.master)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem [256];
  assign bus.Instruction = mem[bus.PCAddress[9:2]];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid;

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic step(input logic rs, input logic st, input logic fl,
                      input logic rd, input logic [31:0] tgt);
    logic [31:0] seq;
    Rst = rs; bus.Stall = st; bus.Flush = fl; bus.Redirect = rd;
    bus.RedirectTarget = tgt;
    seq = m_pc + 32'd4;
    if (rs) begin
      m_pc = TB_RESET_PC; m_instr = TB_NOP; m_pp4 = 0; m_valid = 0;
    end else begin
      if (fl || rd) begin
        m_instr = TB_NOP; m_pp4 = 0; m_valid = 0;
      end else if (!st) begin
        m_instr = mem[m_pc[9:2]]; m_pp4 = seq; m_valid = 1;
      end
      if (rd)       m_pc = tgt & 32'hFFFF_FFFC;
      else if (!st) m_pc = seq;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 0, 1, 32'h0000_0040);
    step(1, 0, 0, 0, 0);
    checks++; if (bus.PCAddress !== TB_RESET_PC) begin errors++;
      $display("FAIL reset_pc: got %h expected %h", bus.PCAddress, TB_RESET_PC); end
    checks++; if (bus.IFID_Valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b expected 0", bus.IFID_Valid); end
    checks++; if (bus.IFID_Instruction !== TB_NOP || bus.IFID_PCPlus4 !== 32'h0) begin errors++;
      $display("FAIL reset_ifid: got %h/%h expected %h/0", bus.IFID_Instruction, bus.IFID_PCPlus4, TB_NOP); end
  endtask

  task automatic test_sequential();
    step(0, 0, 0, 0, 0);
    checks++; if (bus.PCAddress !== 32'h4 || bus.IFID_Instruction !== 32'h3404_0000 ||
                  bus.IFID_PCPlus4 !== 32'h4 || bus.IFID_Valid !== 1'b1) begin errors++;
      $display("FAIL seq_1: got pc=%h ins=%h pp4=%h v=%b expected 4/34040000/4/1",
               bus.PCAddress, bus.IFID_Instruction, bus.IFID_PCPlus4, bus.IFID_Valid); end
    step(0, 0, 0, 0, 0);
    checks++; if (bus.PCAddress !== 32'h8 || bus.IFID_Instruction !== 32'h0800_0004 ||
                  bus.IFID_PCPlus4 !== 32'h8 || bus.IFID_Valid !== 1'b1) begin errors++;
      $display("FAIL seq_2: got pc=%h ins=%h pp4=%h v=%b expected 8/08000004/8/1",
               bus.PCAddress, bus.IFID_Instruction, bus.IFID_PCPlus4, bus.IFID_Valid); end
  endtask

  task automatic test_redirect();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0013);
    checks++; if (bus.PCAddress !== 32'h10 || bus.IFID_Valid !== 1'b0 ||
                  bus.IFID_Instruction !== TB_NOP) begin errors++;
      $display("FAIL redirect_squash: got pc=%h v=%b ins=%h expected 10/0/%h",
               bus.PCAddress, bus.IFID_Valid, bus.IFID_Instruction, TB_NOP); end
    step(0, 0, 0, 0, 0);
    checks++; if (bus.IFID_Instruction !== mem[4] || bus.IFID_PCPlus4 !== 32'h14 ||
                  bus.IFID_Valid !== 1'b1 || bus.PCAddress !== 32'h14) begin errors++;
      $display("FAIL redirect_capture: got ins=%h pp4=%h v=%b pc=%h expected %h/14/1/14",
               bus.IFID_Instruction, bus.IFID_PCPlus4, bus.IFID_Valid, bus.PCAddress, mem[4]); end
  endtask

  task automatic test_stall();
    step(0, 0, 0, 1, 32'h0000_0024);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0);
      checks++; if (bus.PCAddress !== 32'h28 || bus.IFID_Instruction !== mem[9] ||
                    bus.IFID_PCPlus4 !== 32'h28 || bus.IFID_Valid !== 1'b1) begin errors++;
        $display("FAIL stall_hold[%0d]: got pc=%h ins=%h pp4=%h v=%b expected 28/%h/28/1",
                 i, bus.PCAddress, bus.IFID_Instruction, bus.IFID_PCPlus4, bus.IFID_Valid, mem[9]); end
    end
    step(0, 0, 0, 0, 0);
    checks++; if (bus.PCAddress !== 32'h2C || bus.IFID_Instruction !== mem[10] ||
                  bus.IFID_PCPlus4 !== 32'h2C) begin errors++;
      $display("FAIL stall_resume: got pc=%h ins=%h pp4=%h expected 2c/%h/2c",
               bus.PCAddress, bus.IFID_Instruction, bus.IFID_PCPlus4, mem[10]); end
  endtask

  task automatic test_simultaneous();
    step(0, 1, 0, 1, 32'h0000_0100);
    checks++; if (bus.PCAddress !== 32'h100 || bus.IFID_Valid !== 1'b0) begin errors++;
      $display("FAIL stall_redirect: got pc=%h v=%b expected 100/0", bus.PCAddress, bus.IFID_Valid); end
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    checks++; if (bus.PCAddress !== 32'h104 || bus.IFID_Valid !== 1'b0 ||
                  bus.IFID_Instruction !== TB_NOP || bus.IFID_PCPlus4 !== 32'h0) begin errors++;
      $display("FAIL stall_flush: got pc=%h v=%b ins=%h pp4=%h expected 104/0/%h/0",
               bus.PCAddress, bus.IFID_Valid, bus.IFID_Instruction, bus.IFID_PCPlus4, TB_NOP); end
  endtask

  task automatic test_wrap_reset();
    step(0, 0, 0, 1, 32'hFFFF_FFFF);
    checks++; if (bus.PCAddress !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL wrap_target: got %h expected fffffffc", bus.PCAddress); end
    step(0, 0, 0, 0, 0);
    checks++; if (bus.PCAddress !== 32'h0 || bus.IFID_PCPlus4 !== 32'h0 ||
                  bus.IFID_Valid !== 1'b1 || bus.IFID_Instruction !== mem[255]) begin errors++;
      $display("FAIL wrap: got pc=%h pp4=%h v=%b ins=%h expected 0/0/1/%h",
               bus.PCAddress, bus.IFID_PCPlus4, bus.IFID_Valid, bus.IFID_Instruction, mem[255]); end
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 32'h0000_0200);
    checks++; if (bus.PCAddress !== TB_RESET_PC || bus.IFID_Valid !== 1'b0) begin errors++;
      $display("FAIL reset_over_redirect: got pc=%h v=%b expected %h/0",
               bus.PCAddress, bus.IFID_Valid, TB_RESET_PC); end
    step(0, 0, 0, 0, 0);
    checks++; if (bus.PCAddress !== 32'h4 || bus.IFID_Instruction !== 32'h3404_0000) begin errors++;
      $display("FAIL post_reset_fetch: got pc=%h ins=%h expected 4/34040000",
               bus.PCAddress, bus.IFID_Instruction); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic rs, st, fl, rd;
      logic [31:0] tgt;
      rs  = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      tgt = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      step(rs, st, fl, rd, tgt);
      checks++; if (bus.PCAddress !== m_pc || bus.IFID_Instruction !== m_instr ||
                    bus.IFID_PCPlus4 !== m_pp4 || bus.IFID_Valid !== m_valid) begin errors++;
        $display("FAIL random[%0d]: got pc=%h ins=%h pp4=%h v=%b expected %h/%h/%h/%b",
                 i, bus.PCAddress, bus.IFID_Instruction, bus.IFID_PCPlus4, bus.IFID_Valid,
                 m_pc, m_instr, m_pp4, m_valid); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h3404_0000;
    mem[1] = 32'h0800_0004;
    Rst = 1'b1; bus.Stall = 1'b0; bus.Flush = 1'b0; bus.Redirect = 1'b0;
    bus.RedirectTarget = 32'h0;
    m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0;
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_simultaneous();
    test_wrap_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
